sqrt_seq_ctrl: RTL and testbench

FSM controller that sequences the shift/load registers and trial subtractor of the sqrt_ASM integer square-root core. It uses the restoring radix-2 algorithm. The radicand shifts two bits per iteration into the remainder. A trial subtraction sign decides the root bit and whether the remainder is overwritten. It sits between the core's start/done handshake and the datapath strobes: load, shift, load_R0 and in_bit.

---
 rtl/sqrt_seq_ctrl_if.sv | 53 +++++
 rtl/sqrt_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_sqrt_seq_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sqrt_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_seq_ctrl_if
// Description : Handshake and datapath-strobe bundle between the sqrt_ASM
//               controller and its requester/datapath.
//               Macro SQRT_SEQ_CTRL_ABORT_EN adds the abort request line.
//   init    requester -> ctrl  start request (level)
//   neg     datapath  -> ctrl  sign of trial subtraction, 1 = negative
//   abort   requester -> ctrl  cancel a busy run (SQRT_SEQ_CTRL_ABORT_EN only)
//   ld_all, sh_ar, sh_q, ld_r, ld_q0, q_bit   ctrl -> datapath strobes
//   busy, done, iter                          ctrl -> requester status
//   master: requester/datapath side; slave: controller side.
// Revision    : 1.0  initial release
// ============================================================================
interface sqrt_seq_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             init;
  logic             neg;
`ifdef SQRT_SEQ_CTRL_ABORT_EN
  logic             abort;
`endif
  logic             ld_all;
  logic             sh_ar;
  logic             sh_q;
  logic             ld_r;
  logic             ld_q0;
  logic             q_bit;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] iter;

`ifdef SQRT_SEQ_CTRL_ABORT_EN
  modport master (
    output init, neg, abort,
    input  ld_all, sh_ar, sh_q, ld_r, ld_q0, q_bit, busy, done, iter
  );
  modport slave (
    input  init, neg, abort,
    output ld_all, sh_ar, sh_q, ld_r, ld_q0, q_bit, busy, done, iter
  );
`else
  modport master (
    output init, neg,
    input  ld_all, sh_ar, sh_q, ld_r, ld_q0, q_bit, busy, done, iter
  );
  modport slave (
    input  init, neg,
    output ld_all, sh_ar, sh_q, ld_r, ld_q0, q_bit, busy, done, iter
  );
`endif
endinterface
`default_nettype wire

// File: rtl/sqrt_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_seq_ctrl
// Description : Controller for the sqrt_ASM restoring radix-2 integer
//               square-root core. Each iteration shifts two radicand bits
//               into the remainder, settles the trial subtraction
//               R - (4Q+1), then writes the root bit and conditionally the
//               remainder. State advances on posedge; the datapath captures
//               on negedge, so all strobes are Moore outputs.
//   clk    in   core clock
//   reset  in   asynchronous active-low reset
//   bus    slave modport of sqrt_seq_ctrl_if (init/neg[/abort] in,
//          strobes, busy, done, iter out)
//   Optional macro SQRT_SEQ_CTRL_ABORT_EN: abort input cancels a busy run.
// Revision    : 1.0  initial release
// ============================================================================
module sqrt_seq_ctrl #(
  parameter int N_BITS = 16,  // radicand width, even
  parameter int CNT_W  = 4    // 2**CNT_W >= N_BITS/2
) (
  input  wire logic      clk,
  input  wire logic      reset,
  sqrt_seq_ctrl_if.slave bus
);

  localparam int               ITER   = N_BITS / 2;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(ITER - 1);
  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SHA  = 3'd2,
    S_SHB  = 3'd3,
    S_CHK  = 3'd4,
    S_WR   = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic             r_flag,  w_flag_nxt;  // captured sign of trial subtraction

  logic w_ld_all, w_sh_ar, w_sh_q, w_ld_r, w_ld_q0, w_q_bit, w_busy, w_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_flag  <= w_flag_nxt;
    end
  end

  // Next-state and counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_flag_nxt  = r_flag;
    unique case (r_state)
      S_IDLE: if (bus.init) w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_SHA;
      end
      S_SHA:  w_state_nxt = S_SHB;
      S_SHB:  w_state_nxt = S_CHK;
      S_CHK: begin
        // Remainder and root have settled since the SHB negedge.
        w_flag_nxt  = bus.neg;
        w_state_nxt = S_WR;
      end
      S_WR: begin
        if (r_cnt == c_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt   = r_cnt + c_ONE;
          w_state_nxt = S_SHA;
        end
      end
      S_DONE: begin
        // Wait for init to drop so a held request cannot restart the core.
        if (!bus.init) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
`ifdef SQRT_SEQ_CTRL_ABORT_EN
    if (bus.abort && (r_state != S_IDLE) && (r_state != S_DONE)) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_flag_nxt  = 1'b0;
    end
`endif
  end

  // Moore output decode
  always_comb begin
    w_ld_all = 1'b0;
    w_sh_ar  = 1'b0;
    w_sh_q   = 1'b0;
    w_ld_r   = 1'b0;
    w_ld_q0  = 1'b0;
    w_q_bit  = 1'b0;
    w_busy   = 1'b1;
    w_done   = 1'b0;
    unique case (r_state)
      S_IDLE: w_busy = 1'b0;
      S_LOAD: w_ld_all = 1'b1;
      S_SHA: begin
        w_sh_ar = 1'b1;
        w_sh_q  = 1'b1;
      end
      S_SHB:  w_sh_ar = 1'b1;
      S_CHK:  ;
      S_WR: begin
        // Non-negative trial: root bit is 1 and the difference replaces R.
        w_ld_q0 = 1'b1;
        w_q_bit = ~r_flag;
        w_ld_r  = ~r_flag;
      end
      S_DONE: begin
        w_busy = 1'b0;
        w_done = 1'b1;
      end
      default: w_busy = 1'b0;
    endcase
  end

  assign bus.ld_all = w_ld_all;
  assign bus.sh_ar  = w_sh_ar;
  assign bus.sh_q   = w_sh_q;
  assign bus.ld_r   = w_ld_r;
  assign bus.ld_q0  = w_ld_q0;
  assign bus.q_bit  = w_q_bit;
  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.iter   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sqrt_seq_ctrl
// Description : Self-checking bench for sqrt_seq_ctrl with a behavioural
//               negedge datapath; expected roots queued at start, compared
//               at done.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sqrt_seq_ctrl;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  sqrt_seq_ctrl_if #(.CNT_W(4)) bus ();

  sqrt_seq_ctrl #(.N_BITS(16), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: radicand A, remainder R, root Q
  logic [15:0] operand;
  logic [15:0] dp_a;
  logic [11:0] dp_r;
  logic [7:0]  dp_q;
  logic [12:0] dp_trial;
  int          neg_mode;  // 0 = datapath, 1 = force 0, 2 = force 1

  assign dp_trial = {1'b0, dp_r} - 13'({dp_q, 1'b1});
  assign bus.neg  = (neg_mode == 1) ? 1'b0 : (neg_mode == 2) ? 1'b1 : dp_trial[12];

  always @(negedge clk) begin
    if (bus.ld_all) begin
      dp_a <= operand;
      dp_r <= '0;
      dp_q <= '0;
    end else begin
      if (bus.sh_ar) begin
        dp_r <= {dp_r[10:0], dp_a[15]};
        dp_a <= {dp_a[14:0], 1'b0};
      end
      if (bus.sh_q)  dp_q <= {dp_q[6:0], 1'b0};
      if (bus.ld_r)  dp_r <= dp_trial[11:0];
      if (bus.ld_q0) dp_q[0] <= bus.q_bit;
    end
  end

  logic [7:0] sb[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return 8'(r);
  endfunction

  // {ld_all, sh_ar, sh_q, ld_r, ld_q0, q_bit, busy, done, iter[3:0]}
  function automatic logic [11:0] obs();
    return {bus.ld_all, bus.sh_ar, bus.sh_q, bus.ld_r, bus.ld_q0,
            bus.q_bit, bus.busy, bus.done, bus.iter};
  endfunction

  // stop_kind: 0 = full run, 1 = reset in SHB of stop_iter,
  //            2 = abort in CHK of stop_iter
  task automatic run(input logic [15:0] op, input int mode, input bit toggle,
                     input int stop_kind, input int stop_iter);
    logic [7:0] root;
    logic       eq;
    root     = isqrt(int'(op));
    operand  = op;
    neg_mode = mode;
    if (mode == 0 && stop_kind == 0) sb.push_back(root);
    bus.init = 1'b1;
    @(posedge clk); #1;
    check("load", 32'(obs()), 32'({8'b1000_0010, 4'd0}));
    bus.init = 1'b0;
    for (int i = 0; i < 8; i++) begin
      eq = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : root[7-i];
      @(posedge clk); #1;
      check("sha", 32'(obs()), 32'({8'b0110_0010, 4'(i)}));
      if (toggle) bus.init = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("shb", 32'(obs()), 32'({8'b0100_0010, 4'(i)}));
      if (stop_kind == 1 && i == stop_iter) begin
        bus.init = 1'b0;
        #2 reset = 1'b0;
        #1 check("rst_async", 32'(obs()), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        check("rst_idle", 32'(obs()), 32'h0);
        return;
      end
      if (toggle) bus.init = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("chk", 32'(obs()), 32'({8'b0000_0010, 4'(i)}));
`ifdef SQRT_SEQ_CTRL_ABORT_EN
      if (stop_kind == 2 && i == stop_iter) begin
        bus.init  = 1'b0;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort_idle", 32'(obs()), 32'h0);
        return;
      end
`endif
      if (toggle) bus.init = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("wr", 32'(obs()), 32'({3'b000, eq, 1'b1, eq, 2'b10, 4'(i)}));
      bus.init = (toggle && i < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(posedge clk); #1;
    check("done", 32'(obs()), 32'({8'b0000_0001, 4'd7}));
    if (mode == 0) begin
      if (sb.size() == 0) check("sb_empty", 32'(sb.size()), 32'd1);
      else                check("root", 32'(dp_q), 32'(sb.pop_front()));
    end
  endtask

  task automatic expect_idle(input string tag);
    @(posedge clk); #1;
    check(tag, 32'(obs()), 32'h0);
  endtask

  initial begin
    reset    = 1'b0;
    bus.init = 1'b0;
    neg_mode = 0;
    operand  = '0;
`ifdef SQRT_SEQ_CTRL_ABORT_EN
    bus.abort = 1'b0;
`endif
    #13;
    check("reset_state", 32'(obs()), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    run(16'd0, 1, 1'b0, 0, 0);       // neg held 0
    expect_idle("idle_a");
    run(16'd0, 2, 1'b0, 0, 0);       // neg held 1
    expect_idle("idle_b");
    run(16'd144, 0, 1'b1, 0, 0);     // init toggling while busy
    expect_idle("idle_c");
    run(16'd65535, 0, 1'b0, 0, 0);
    expect_idle("idle_d");
    run(16'd0, 0, 1'b0, 0, 0);
    expect_idle("idle_e");
    run(16'd2, 0, 1'b0, 0, 0);

    // init held through DONE: no restart until it drops
    bus.init = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("done_hold", 32'(obs()), 32'({8'b0000_0001, 4'd7}));
    end
    bus.init = 1'b0;
    expect_idle("idle_after_hold");
    run(16'd1000, 0, 1'b0, 0, 0);
    expect_idle("idle_f");

    run(16'd100, 0, 1'b0, 1, 3);     // reset mid-run
    run(16'd200, 0, 1'b0, 0, 0);
    expect_idle("idle_g");

`ifdef SQRT_SEQ_CTRL_ABORT_EN
    run(16'd50000, 0, 1'b0, 2, 5);   // abort mid-run
    run(16'd50000, 0, 1'b0, 0, 0);
    expect_idle("idle_h");
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
